// File: rtl/vr_mem_pkg.sv
// vr_mem_pkg: shared encodings and defaults for the data-memory arbiter slice
package vr_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int DEF_MEM_WORDS = 1024;
endpackage

// File: rtl/vr_dmem_arbiter_if.sv
// vr_dmem_arbiter_if: two requester ports plus the single-port memory bus
interface vr_dmem_arbiter_if;
  logic        REQ0, LOCK0, RW0, GNT0, RESP0, ERR0;
  logic [31:0] ADDR0, WD0, RDATA0;
  logic        REQ1, LOCK1, RW1, GNT1, RESP1, ERR1;
  logic [31:0] ADDR1, WD1, RDATA1;
  logic [31:0] M_ADDR, M_WD, M_RD;
  logic        M_RW;
  modport master (
    output REQ0, LOCK0, ADDR0, RW0, WD0, REQ1, LOCK1, ADDR1, RW1, WD1, M_RD,
    input  GNT0, RESP0, ERR0, RDATA0, GNT1, RESP1, ERR1, RDATA1, M_ADDR, M_RW, M_WD
  );
  modport slave (
    input  REQ0, LOCK0, ADDR0, RW0, WD0, REQ1, LOCK1, ADDR1, RW1, WD1, M_RD,
    output GNT0, RESP0, ERR0, RDATA0, GNT1, RESP1, ERR1, RDATA1, M_ADDR, M_RW, M_WD
  );
endinterface

// File: rtl/vr_rr_pick.sv
// vr_rr_pick: 2-way round-robin grant with lock-owner override
import vr_mem_pkg::*;
module vr_rr_pick (
  input  logic       en,
  input  logic [1:0] req,
  input  state_t     state,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);
  always_comb
    gnt = !en            ? 2'b00 :
          state == OWN0  ? {1'b0, req[0]} :
          state == OWN1  ? {req[1], 1'b0} :
          &req           ? (rr_ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/vr_dmem_arbiter.sv
// vr_dmem_arbiter: round-robin, lock-bounded sharing of one data memory
// between two requesters, with range/alignment checks and registered returns.
import vr_mem_pkg::*;
module vr_dmem_arbiter #(
  parameter int MAX_LOCK  = 8,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input logic CLK,
  input logic RST_N,
  vr_dmem_arbiter_if.slave bus
);
  localparam logic [32:0] ADDR_LIM = 33'(4 * MEM_WORDS);
  localparam logic [8:0]  LOCK_LIM = 9'(MAX_LOCK);
  state_t      state, state_nx;
  logic        rr_ptr, rr_nx, sel, legal, lk;
  logic [7:0]  lock_cnt, cnt_nx;
  logic [1:0]  gnt, resp, err;
  logic [31:0] addr, rdata0, rdata1;
  vr_rr_pick u_pick (
    .en    (RST_N),
    .req   ({bus.REQ1, bus.REQ0}),
    .state (state),
    .rr_ptr(rr_ptr),
    .gnt   (gnt)
  );
  assign sel        = gnt[1];
  assign addr       = sel ? bus.ADDR1 : bus.ADDR0;
  assign lk         = sel ? bus.LOCK1 : bus.LOCK0;
  assign legal      = ({1'b0, addr} < ADDR_LIM) && (addr[1:0] == 2'b00);
  assign bus.M_ADDR = addr;
  assign bus.M_WD   = sel ? bus.WD1 : bus.WD0;
  assign bus.M_RW   = (sel ? bus.RW1 : bus.RW0) & (|gnt) & legal;
  assign bus.GNT0   = gnt[0];
  assign bus.GNT1   = gnt[1];
  assign bus.RESP0  = resp[0];
  assign bus.RESP1  = resp[1];
  assign bus.ERR0   = err[0];
  assign bus.ERR1   = err[1];
  assign bus.RDATA0 = rdata0;
  assign bus.RDATA1 = rdata1;
  // lock_cnt is 0 in IDLE, so one bound test covers both entry and extension
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    cnt_nx   = lock_cnt;
    if (|gnt) begin
      if (lk && ({1'b0, lock_cnt} + 9'd1 < LOCK_LIM)) begin
        state_nx = sel ? OWN1 : OWN0;
        cnt_nx   = lock_cnt + 8'd1;
      end else begin
        state_nx = IDLE;
        rr_nx    = ~sel;
        cnt_nx   = '0;
      end
    end else if (state != IDLE) begin
      state_nx = IDLE;
      rr_nx    = (state == OWN0);
      cnt_nx   = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
      resp     <= '0;
      err      <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      lock_cnt <= cnt_nx;
      resp     <= gnt;
      err      <= gnt & {2{~legal}};
      if (gnt[0] && (!legal || bus.RW0 == RW_READ)) rdata0 <= legal ? bus.M_RD : '0;
      if (gnt[1] && (!legal || bus.RW1 == RW_READ)) rdata1 <= legal ? bus.M_RD : '0;
    end
  end
endmodule

// File: tb/tb_vr_dmem_arbiter.sv
// tb_vr_dmem_arbiter: directed vectors against hand-computed grant/response values
import vr_mem_pkg::*;
module tb_vr_dmem_arbiter;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  logic [31:0] mem [0:1023] = '{0: 32'd1, 1: 32'd9, default: 32'd0};
  logic [1:0]  lk_exp [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
  vr_dmem_arbiter_if bus();
  vr_dmem_arbiter #(.MAX_LOCK(4)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));
  always #5 CLK = ~CLK;
  assign bus.M_RD = mem[bus.M_ADDR[11:2]];
  always @(posedge CLK) if (bus.M_RW) mem[bus.M_ADDR[11:2]] <= bus.M_WD;
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task tick;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    bus.REQ0 = 1'b1; bus.LOCK0 = 1'b0; bus.RW0 = RW_READ; bus.ADDR0 = 32'h0; bus.WD0 = '0;
    bus.REQ1 = 1'b1; bus.LOCK1 = 1'b0; bus.RW1 = RW_READ; bus.ADDR1 = 32'h4; bus.WD1 = '0;
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
      check("rst_mrw", 32'(bus.M_RW), 32'd0);
      check("rst_resp", 32'({bus.RESP1, bus.RESP0}), 32'd0);
      check("rst_rdata0", bus.RDATA0, 32'd0);
      check("rst_rdata1", bus.RDATA1, 32'd0);
      tick;
    end
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("cont_gnt", 32'({bus.GNT1, bus.GNT0}), i[0] ? 32'd2 : 32'd1);
      if (i > 0) begin
        check("cont_resp", 32'({bus.RESP1, bus.RESP0}), i[0] ? 32'd1 : 32'd2);
        check("cont_rdata", i[0] ? bus.RDATA0 : bus.RDATA1, i[0] ? 32'd1 : 32'd9);
      end
      tick;
    end
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    @(negedge CLK);
    check("cont_last_resp1", 32'(bus.RESP1), 32'd1);
    check("cont_last_rdata1", bus.RDATA1, 32'd9);
    tick;
    bus.REQ1 = 1'b1; bus.RW1 = RW_WRITE; bus.ADDR1 = 32'h20; bus.WD1 = 32'hDEADBEEF;
    @(negedge CLK);
    check("wr_gnt1", 32'(bus.GNT1), 32'd1);
    check("wr_mrw", 32'(bus.M_RW), 32'd1);
    check("wr_maddr", bus.M_ADDR, 32'h20);
    tick;
    bus.RW1 = RW_READ;
    @(negedge CLK);
    check("rd_gnt1", 32'(bus.GNT1), 32'd1);
    check("rd_mrw", 32'(bus.M_RW), 32'd0);
    check("wr_resp1", 32'({bus.ERR1, bus.RESP1}), 32'd1);
    check("wr_rdata_kept", bus.RDATA1, 32'd9);
    tick;
    bus.REQ1 = 1'b0;
    @(negedge CLK);
    check("rd_resp1", 32'({bus.ERR1, bus.RESP1}), 32'd1);
    check("rd_rdata1", bus.RDATA1, 32'hDEADBEEF);
    check("wr_mem", mem[8], 32'hDEADBEEF);
    tick;
    bus.REQ0 = 1'b1; bus.LOCK0 = 1'b1; bus.ADDR0 = 32'h0;
    bus.REQ1 = 1'b1; bus.ADDR1 = 32'h4;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check($sformatf("lock_gnt%0d", i), 32'({bus.GNT1, bus.GNT0}), 32'(lk_exp[i]));
      tick;
    end
    bus.REQ0 = 1'b0; bus.LOCK0 = 1'b0; bus.REQ1 = 1'b0;
    @(negedge CLK);
    check("lock_idle_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
    check("lock_resp0", 32'(bus.RESP0), 32'd1);
    tick;
    bus.REQ0 = 1'b1; bus.RW0 = RW_WRITE; bus.ADDR0 = 32'h1000; bus.WD0 = 32'h12345678;
    @(negedge CLK);
    check("oor_gnt0", 32'(bus.GNT0), 32'd1);
    check("oor_mrw", 32'(bus.M_RW), 32'd0);
    tick;
    bus.RW0 = RW_READ; bus.ADDR0 = 32'h6;
    @(negedge CLK);
    check("mis_gnt0", 32'(bus.GNT0), 32'd1);
    check("mis_mrw", 32'(bus.M_RW), 32'd0);
    check("oor_resp_err", 32'({bus.ERR0, bus.RESP0}), 32'd3);
    check("oor_rdata0", bus.RDATA0, 32'd0);
    tick;
    bus.REQ0 = 1'b0; bus.ADDR0 = 32'h0;
    @(negedge CLK);
    check("mis_resp_err", 32'({bus.ERR0, bus.RESP0}), 32'd3);
    check("mis_rdata0", bus.RDATA0, 32'd0);
    check("oor_mem0", mem[0], 32'd1);
    check("oor_mem1", mem[1], 32'd9);
    tick;
    bus.REQ1 = 1'b1; bus.LOCK1 = 1'b1; bus.ADDR1 = 32'h4;
    @(negedge CLK);
    check("ml_gnt1", 32'({bus.GNT1, bus.GNT0}), 32'd2);
    tick;
    RST_N = 1'b0;
    @(negedge CLK);
    check("ml_rst_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
    check("ml_rst_mrw", 32'(bus.M_RW), 32'd0);
    tick;
    RST_N = 1'b1; bus.REQ0 = 1'b1; bus.LOCK1 = 1'b0;
    @(negedge CLK);
    check("ml_no_resp1", 32'(bus.RESP1), 32'd0);
    check("ml_rdata1", bus.RDATA1, 32'd0);
    check("ml_gnt_after", 32'({bus.GNT1, bus.GNT0}), 32'd1);
    tick;
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    @(negedge CLK);
    check("ml_resp0", 32'({bus.ERR0, bus.RESP0}), 32'd1);
    check("ml_rdata0", bus.RDATA0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vr_dmem_arbiter.md
Name: vr_dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (Vr_data_mem). It shares that memory between requester 0 (CPU data port) and requester 1 (loader/debug/DMA port). The block provides round-robin arbitration, optional bounded locking for back-to-back bursts, range and alignment checking, and registered read return. Each access takes one memory cycle; the response is returned on the following cycle.

Parameters:
MAX_LOCK, 8, maximum consecutive cycles one requester may hold a lock before it is forcibly released (range 1..255)
MEM_WORDS, 1024, number of 32-bit words in the memory; legal byte addresses are 0..4*MEM_WORDS-1

Ports:
CLK  in  1  clock; all state updates on posedge
RST_N  in  1  reset, synchronous, active-low
REQ0  in  1  requester 0 access request; held until GNT0
LOCK0  in  1  requester 0 wants to keep ownership after this access
ADDR0  in  32  requester 0 byte address
RW0  in  1  requester 0 access type; 0 = read, 1 = write
WD0  in  32  requester 0 write data
GNT0  out  1  combinational; requester 0 access is accepted this cycle
RESP0  out  1  one-cycle pulse, one cycle after GNT0
ERR0  out  1  qualifies RESP0; the access was rejected
RDATA0  out  32  read data, valid while RESP0=1 for a read
REQ1, LOCK1, ADDR1, RW1, WD1, GNT1, RESP1, ERR1, RDATA1: same as the requester 0 ports, for requester 1
M_ADDR  out  32  memory address
M_RW  out  1  memory write enable; 0 = read, 1 = write
M_WD  out  32  memory write data
M_RD  in  32  memory combinational read data

Behaviour:
- Reset (RST_N=0 at posedge): state=IDLE; rr_ptr=0 (requester 0 preferred); lock_cnt=0; RESPx=0; ERRx=0; RDATAx=0. While in reset, GNTx=0 and M_RW=0. Reset mid-access drops any pending response and blocks the write. M_RW is 0 during reset, so the posedge that samples reset does not write.
- FSM states:
  - IDLE: no owner.
  - OWN0, OWN1: locked owner.
- Grant in IDLE:
  - Only one REQx high: that requester is granted.
  - Both high: the requester at rr_ptr is granted.
  - After a grant without lock, rr_ptr = the other requester.
- Grant in OWNx: only requester x can be granted. The other requester is starved until the lock is released.
- Transitions:
  - IDLE -> OWNx: when x is granted with LOCKx=1; lock_cnt=1.
  - OWNx -> OWNx: on a granted access with LOCKx=1 and lock_cnt<MAX_LOCK; lock_cnt increments.
  - OWNx -> IDLE: when LOCKx=0 at a granted access, when REQx=0, or when lock_cnt reaches MAX_LOCK. On exit, rr_ptr = the other requester and lock_cnt=0.
- Memory mux: M_ADDR and M_WD come from the granted requester, else from requester 0.
  - M_RW = RWx & GNTx & legal.
  - legal = (ADDRx < 4*MEM_WORDS) && (ADDRx[1:0]==0).
- Write commit: a legal write is written by the memory at the posedge that ends the grant cycle.
- Read: M_RD is captured into RDATAx at that same posedge.
- Response: RESPx=1 in the cycle after GNTx, for reads and writes alike.
  - ERRx=1 for an illegal access; RDATAx=0 and no write occurs.
  - Write responses leave RDATAx unchanged.
- Back-to-back: a new grant is allowed every cycle. RESP of access n coincides with GNT of access n+1.
- The arbiter never grants both requesters in the same cycle. At most one M_RW pulse occurs per cycle.

Decomposition:
- Shared package vr_mem_pkg holds:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2)
  - RW_READ=1'b0, RW_WRITE=1'b1
  - MEM_WORDS default
- One natural sub-module: vr_rr_pick. It is combinational and implements the 2-way round-robin priority with lock override, producing the GNT vector.
- The response registers and FSM stay in the top module.

Test Plan:
- Reset: hold RST_N=0 three cycles with REQ0=REQ1=1 -> GNT0=GNT1=0, M_RW=0, RESP*=0, RDATA*=0. First grant after release goes to requester 0.
- Contention: both REQ every cycle, reads at ADDR0=0 and ADDR1=4, memory preloaded with words 1 and 9 -> grants alternate 0,1,0,1. RESP0 returns RDATA0=1 and RESP1 returns RDATA1=9, each one cycle after its grant.
- Write-then-read: requester 1 writes 0xDEADBEEF to 0x20, then reads 0x20 on the next cycle -> the read returns 0xDEADBEEF. ERR1=0.
- Lock bound with MAX_LOCK=4: requester 0 holds LOCK0=1 and REQ0=1 while REQ1=1 -> exactly 4 consecutive GNT0, then one GNT1, then requester 0 again.
- Illegal access: write to 0x1000 (out of range), then read at 0x6 (misaligned) -> M_RW stays 0, memory is unchanged, ERR=1 with RESP on the following cycle, RDATA=0.
- Reset mid-lock: assert RST_N=0 while in OWN1 with a read just granted -> no RESP1 pulse. State returns to IDLE and rr_ptr=0.
